alu_ctrl_mdu: RTL and testbench

Parametrised successor to the single-cycle ALU control decoder. Decodes `alu_op`/`funct` into the ALU operation code and `jr` flag as before, and adds HI/LO multiply/divide support: issue, latency tracking, pipeline stall and HI/LO write-enable for MULT/MULTU/DIV/DIVU/MFHI/MFLO. Sits between the main control unit and the datapath ALU, HI/LO registers and an external iterative multiply/divide unit (MDU).

---
 rtl/mips_pkg.sv | 55 +++++
 rtl/alu_ctrl_mdu_if.sv | 29 ++
 rtl/alu_ctrl_mdu_decode.sv | 57 +++++
 rtl/alu_ctrl_mdu.sv | 86 ++++++++
 tb/tb_alu_ctrl_mdu.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the ALU control decoder and the HI/LO multiply/divide sequencer.
package mips_pkg;

  // alu_op from the main control unit
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpEq    = 2'b01;
  localparam logic [1:0] AluOpRtype = 2'b10;

  // ALU operation codes (zero-extended to the configured width at the use site)
  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSll = 4'b0011;
  localparam logic [3:0] AluSrl = 4'b1000;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;
  localparam logic [3:0] AluEq  = 4'b1111;
  localparam logic [3:0] AluNop = 4'b0000;

  // R-type funct field values
  localparam logic [5:0] FunctAdd   = 6'b100000;
  localparam logic [5:0] FunctSub   = 6'b100010;
  localparam logic [5:0] FunctAnd   = 6'b100100;
  localparam logic [5:0] FunctOr    = 6'b100101;
  localparam logic [5:0] FunctNor   = 6'b100111;
  localparam logic [5:0] FunctSlt   = 6'b101010;
  localparam logic [5:0] FunctSll   = 6'b000000;
  localparam logic [5:0] FunctSrl   = 6'b000010;
  localparam logic [5:0] FunctJr    = 6'b001000;
  localparam logic [5:0] FunctMfhi  = 6'b010000;
  localparam logic [5:0] FunctMflo  = 6'b010010;
  localparam logic [5:0] FunctMult  = 6'b011000;
  localparam logic [5:0] FunctMultu = 6'b011001;
  localparam logic [5:0] FunctDiv   = 6'b011010;
  localparam logic [5:0] FunctDivu  = 6'b011011;

  // mdu_op encodings; bit 1 selects divide
  localparam logic [1:0] MduMult  = 2'b00;
  localparam logic [1:0] MduMultu = 2'b01;
  localparam logic [1:0] MduDiv   = 2'b10;
  localparam logic [1:0] MduDivu  = 2'b11;

  // Writeback source select
  localparam logic [1:0] ResAlu = 2'b00;
  localparam logic [1:0] ResHi  = 2'b01;
  localparam logic [1:0] ResLo  = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/alu_ctrl_mdu_if.sv
// Decode-stage to ALU-control bus: instruction fields in, ALU/MDU control out.
interface alu_ctrl_mdu_if #(
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned FUNCT_W    = 6
);
  logic                  instr_valid;
  logic [1:0]            alu_op;
  logic [FUNCT_W-1:0]    funct;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  jr;
  logic                  mdu_start;
  logic [1:0]            mdu_op;
  logic                  mdu_busy;
  logic                  hilo_we;
  logic [1:0]            res_sel;
  logic                  stall;

  // Control unit / decode stage side
  modport master (
    output instr_valid, alu_op, funct,
    input  alu_ctrl, jr, mdu_start, mdu_op, mdu_busy, hilo_we, res_sel, stall
  );

  // ALU control block side
  modport slave (
    input  instr_valid, alu_op, funct,
    output alu_ctrl, jr, mdu_start, mdu_op, mdu_busy, hilo_we, res_sel, stall
  );
endinterface

// File: rtl/alu_ctrl_mdu_decode.sv
// Purely combinational alu_op/funct decode: ALU code, jr, MDU/MF class flags, writeback select.
module alu_ctrl_mdu_decode
  import mips_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned FUNCT_W    = 6
) (
  input  logic [1:0]            alu_op_i,
  input  logic [FUNCT_W-1:0]    funct_i,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
  output logic                  jr_o,
  output logic                  mdu_class_o,
  output logic                  mf_class_o,
  output logic [1:0]            res_sel_o
);

  // Decode the instruction class and ALU operation; anything unlisted yields the zero code.
  always_comb begin
    alu_ctrl_o  = '0;
    jr_o        = 1'b0;
    mdu_class_o = 1'b0;
    mf_class_o  = 1'b0;
    res_sel_o   = ResAlu;
    case (alu_op_i)
      AluOpAdd: alu_ctrl_o = ALU_CTRL_W'(AluAdd);
      AluOpEq:  alu_ctrl_o = ALU_CTRL_W'(AluEq);
      AluOpRtype: begin
        case (funct_i)
          FUNCT_W'(FunctAdd):   alu_ctrl_o = ALU_CTRL_W'(AluAdd);
          FUNCT_W'(FunctSub):   alu_ctrl_o = ALU_CTRL_W'(AluSub);
          FUNCT_W'(FunctAnd):   alu_ctrl_o = ALU_CTRL_W'(AluAnd);
          FUNCT_W'(FunctOr):    alu_ctrl_o = ALU_CTRL_W'(AluOr);
          FUNCT_W'(FunctNor):   alu_ctrl_o = ALU_CTRL_W'(AluNor);
          FUNCT_W'(FunctSlt):   alu_ctrl_o = ALU_CTRL_W'(AluSlt);
          FUNCT_W'(FunctSll):   alu_ctrl_o = ALU_CTRL_W'(AluSll);
          FUNCT_W'(FunctSrl):   alu_ctrl_o = ALU_CTRL_W'(AluSrl);
          FUNCT_W'(FunctJr):    jr_o = 1'b1;
          FUNCT_W'(FunctMfhi): begin
            mf_class_o = 1'b1;
            res_sel_o  = ResHi;
          end
          FUNCT_W'(FunctMflo): begin
            mf_class_o = 1'b1;
            res_sel_o  = ResLo;
          end
          FUNCT_W'(FunctMult),
          FUNCT_W'(FunctMultu),
          FUNCT_W'(FunctDiv),
          FUNCT_W'(FunctDivu):  mdu_class_o = 1'b1;
          default:              alu_ctrl_o = ALU_CTRL_W'(AluNop);
        endcase
      end
      default: alu_ctrl_o = ALU_CTRL_W'(AluNop);
    endcase
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with HI/LO multiply/divide issue, latency tracking and stall generation.
module alu_ctrl_mdu
  import mips_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned FUNCT_W    = 6,
  parameter int unsigned MUL_LAT    = 4,
  parameter int unsigned DIV_LAT    = 32
) (
  input  logic          clk,
  input  logic          rst,
  alu_ctrl_mdu_if.slave bus
);

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  logic       mdu_class;
  logic       mf_class;
  logic       issue;
  mdu_state_e state_q;
  logic [CntW-1:0] cnt_q;
  logic       busy_q;
  logic       hilo_we_q;

  alu_ctrl_mdu_decode #(
    .ALU_CTRL_W(ALU_CTRL_W),
    .FUNCT_W   (FUNCT_W)
  ) u_decode (
    .alu_op_i   (bus.alu_op),
    .funct_i    (bus.funct),
    .alu_ctrl_o (bus.alu_ctrl),
    .jr_o       (bus.jr),
    .mdu_class_o(mdu_class),
    .mf_class_o (mf_class),
    .res_sel_o  (bus.res_sel)
  );

  // Launch only from IDLE; reset masks launch and stall while it is held.
  always_comb begin
    issue         = bus.instr_valid & mdu_class & (state_q == StIdle) & ~rst;
    bus.mdu_start = issue;
    bus.mdu_op    = bus.funct[1:0];
    bus.stall     = bus.instr_valid & (mdu_class | mf_class) & busy_q & ~rst;
    bus.mdu_busy  = busy_q;
    bus.hilo_we   = hilo_we_q;
  end

  // Sequencer: count the MDU latency, then pulse hilo_we for one cycle on the way back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hilo_we_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            cnt_q   <= bus.funct[1] ? CntW'(DIV_LAT) : CntW'(MUL_LAT);
            state_q <= StBusy;
            busy_q  <= 1'b1;
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            state_q   <= StDone;
            hilo_we_q <= 1'b1;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          hilo_we_q <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          hilo_we_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Scoreboard bench: driver pushes expected outputs per cycle, negedge monitor pops and compares.
module tb_alu_ctrl_mdu;

  localparam int MulLat = 4;
  localparam int DivLat = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_ctrl_mdu_if #(.ALU_CTRL_W(4), .FUNCT_W(6)) bus ();

  alu_ctrl_mdu #(
    .ALU_CTRL_W(4),
    .FUNCT_W   (6),
    .MUL_LAT   (MulLat),
    .DIV_LAT   (DivLat)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] alu_ctrl;
    logic       jr;
    logic [1:0] res_sel;
    logic       stall;
    logic       start;
    logic [1:0] op;
    logic       busy;
    logic       hilo_we;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: an operation issued in cycle I with latency L keeps the unit busy in
  // cycles I+1 .. I+L+1 and writes HI/LO in cycle I+L+1.
  bit m_active = 0;
  int m_issue  = 0;
  int m_lat    = 0;

  function automatic logic [3:0] ref_alu(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b1111;
    if (op == 2'b11) return 4'b0000;
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100111: return 4'b1100;
      6'b101010: return 4'b0111;
      6'b000000: return 4'b0011;
      6'b000010: return 4'b1000;
      default:   return 4'b0000;
    endcase
  endfunction

  task automatic check(input int c, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL cyc=%0d %s actual=%0h expected=%0h", c, name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must be during that cycle.
  task automatic step(input logic r, input logic v, input logic [1:0] op, input logic [5:0] f);
    exp_t e;
    bit   is_mdu;
    bit   is_mf;
    @(posedge clk);
    #1;
    rst             = r;
    bus.instr_valid = v;
    bus.alu_op      = op;
    bus.funct       = f;
    is_mdu = (op == 2'b10) && (f >= 6'd24) && (f <= 6'd27);
    is_mf  = (op == 2'b10) && (f == 6'd16 || f == 6'd18);
    if (r) m_active = 0;
    e.cyc      = cyc;
    e.alu_ctrl = ref_alu(op, f);
    e.jr       = (op == 2'b10) && (f == 6'd8);
    e.res_sel  = !(op == 2'b10) ? 2'd0 : (f == 6'd16) ? 2'd1 : (f == 6'd18) ? 2'd2 : 2'd0;
    e.busy     = m_active && (cyc > m_issue) && (cyc <= m_issue + m_lat + 1);
    e.hilo_we  = m_active && (cyc == m_issue + m_lat + 1);
    e.stall    = !r && v && (is_mdu || is_mf) && e.busy;
    e.start    = !r && v && is_mdu && !e.busy;
    e.op       = f[1:0];
    if (e.start) begin
      m_active = 1;
      m_issue  = cyc;
      m_lat    = f[1] ? DivLat : MulLat;
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 6'b0);
  endtask

  // Monitor: compare every queued cycle at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.cyc, "alu_ctrl", int'(bus.alu_ctrl), int'(e.alu_ctrl));
        check(e.cyc, "jr", int'(bus.jr), int'(e.jr));
        check(e.cyc, "res_sel", int'(bus.res_sel), int'(e.res_sel));
        check(e.cyc, "stall", int'(bus.stall), int'(e.stall));
        check(e.cyc, "mdu_start", int'(bus.mdu_start), int'(e.start));
        check(e.cyc, "mdu_busy", int'(bus.mdu_busy), int'(e.busy));
        check(e.cyc, "hilo_we", int'(bus.hilo_we), int'(e.hilo_we));
        if (e.start) check(e.cyc, "mdu_op", int'(bus.mdu_op), int'(e.op));
      end
    end
  end

  logic [5:0] sweep [17] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                             6'b101010, 6'b000000, 6'b000010, 6'b001000, 6'b111111,
                             6'b010000, 6'b010010, 6'b011000, 6'b011001, 6'b011010,
                             6'b011011, 6'b000001};

  initial begin
    bus.instr_valid = 1'b0;
    bus.alu_op      = 2'b00;
    bus.funct       = 6'b0;

    // Reset held, including a launch-looking instruction that must be masked
    step(1'b1, 1'b0, 2'b00, 6'b0);
    step(1'b1, 1'b1, 2'b10, 6'b011000);
    idle(1);

    // Decode sweep (non-MDU entries only, so nothing launches)
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 2'b10, sweep[i]);
    step(1'b0, 1'b1, 2'b00, 6'b101010);
    step(1'b0, 1'b1, 2'b01, 6'b000000);
    step(1'b0, 1'b1, 2'b11, 6'b100000);

    // MULT issue and completion
    step(1'b0, 1'b1, 2'b10, 6'b011000);
    idle(MulLat + 3);

    // DIVU then MFLO held until it proceeds
    step(1'b0, 1'b1, 2'b10, 6'b011011);
    for (int i = 0; i < DivLat + 2; i++) step(1'b0, 1'b1, 2'b10, 6'b010010);
    idle(1);

    // ADD and dropped-valid MFHI during DIV busy
    step(1'b0, 1'b1, 2'b10, 6'b011010);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'b10, 6'b100000);
    step(1'b0, 1'b1, 2'b10, 6'b010000);
    step(1'b0, 1'b0, 2'b10, 6'b010000);
    idle(DivLat);

    // Back-to-back MULT / MULTU
    step(1'b0, 1'b1, 2'b10, 6'b011000);
    for (int i = 0; i < MulLat + 3; i++) step(1'b0, 1'b1, 2'b10, 6'b011001);
    idle(MulLat + 3);

    // Reset mid-DIV at cycle 10, then a normal MULT
    step(1'b0, 1'b1, 2'b10, 6'b011010);
    idle(9);
    step(1'b1, 1'b0, 2'b00, 6'b0);
    idle(1);
    step(1'b0, 1'b1, 2'b10, 6'b011000);
    idle(MulLat + 3);

    // Random traffic biased toward MDU/MF instructions
    for (int i = 0; i < 600; i++) begin
      logic [5:0] f;
      logic [1:0] op;
      f  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : sweep[$urandom_range(0, 16)];
      op = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b10;
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 3) != 0), op, f);
    end
    idle(2);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
